// File: rtl/router_pkg.sv
// Shared types and helpers for the 1x3 router and its packet framer.
// Also used by router-side checkers that need the same header layout.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_e;

  // Header byte: payload length in the upper six bits, destination in the lower two.
  function automatic logic [7:0] make_header(input logic [LEN_W-1:0]  len,
                                             input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload store for the framer: one synchronous write port and one
// combinational read port.
module router_pkt_buf
  import router_pkg::*;
#(
  parameter int DEPTH = 63,
  parameter int AW    = LEN_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; every byte is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/router_pkt_framer.sv
// Store-and-forward packet source for the 1x3 router: header, payload, XOR parity.
// Optional build macro ROUTER_FRAMER_PARITY_CORRUPT_EN adds a corrupt_parity request input.
module router_pkt_framer
  import router_pkg::*;
#(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_ready,
  input  logic              pl_valid,
  input  logic [7:0]        pl_data,
  output logic              pl_ready,
  input  logic              busy,
`ifdef ROUTER_FRAMER_PARITY_CORRUPT_EN
  input  logic              corrupt_parity,
`endif
  output logic [7:0]        rtr_data,
  output logic              rtr_pkt_valid,
  output logic              pkt_sent,
  output logic              req_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [7:0]         hdr_q, hdr_d;
  logic [7:0]         parity_q, parity_d;
  logic [LEN_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]         rtr_data_q, rtr_data_d;
  logic               rtr_pkt_valid_q, rtr_pkt_valid_d;
  logic               pkt_sent_q, pkt_sent_d;
  logic               req_err_q, req_err_d;

  logic               wr_en;
  logic [7:0]         rd_data;
  logic [7:0]         parity_mask;
  logic [LEN_W-1:0]   len_q;
  logic               req_fire;

  assign len_q    = hdr_q[7:2];
  assign req_fire = (state_q == ST_IDLE) && req_valid;

  router_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LEN_W)
  ) u_buf (
    .clk     (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (pl_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

`ifdef ROUTER_FRAMER_PARITY_CORRUPT_EN
  logic corrupt_q, corrupt_d;

  always_comb begin
    corrupt_d = corrupt_q;
    if (req_fire) corrupt_d = corrupt_parity;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) corrupt_q <= 1'b0;
    else       corrupt_q <= corrupt_d;
  end

  assign parity_mask = {7'b0, corrupt_q};
`else
  assign parity_mask = 8'h00;
`endif

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    hdr_d           = hdr_q;
    parity_d        = parity_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    gap_cnt_d       = gap_cnt_q;
    rtr_data_d      = rtr_data_q;
    rtr_pkt_valid_d = rtr_pkt_valid_q;
    pkt_sent_d      = 1'b0;
    req_err_d       = 1'b0;
    wr_en           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          if (req_len == '0 || req_addr == ADDR_ILLEGAL) begin
            req_err_d = 1'b1;
          end else begin
            hdr_d    = make_header(req_len, req_addr);
            parity_d = make_header(req_len, req_addr);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (pl_valid) begin
          wr_en    = 1'b1;
          parity_d = parity_q ^ pl_data;
          wr_ptr_d = wr_ptr_q + LEN_W'(1);
          if (wr_ptr_q == len_q - LEN_W'(1)) begin
            rtr_data_d      = hdr_q;
            rtr_pkt_valid_d = 1'b1;
            state_d         = ST_HEADER;
          end
        end
      end
      // rd_ptr_q is still 0 here, so rd_data already presents the first payload byte.
      ST_HEADER: begin
        if (!busy) begin
          rtr_data_d = rd_data;
          rd_ptr_d   = rd_ptr_q + LEN_W'(1);
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          if (rd_ptr_q == len_q) begin
            rtr_data_d      = parity_q ^ parity_mask;
            rtr_pkt_valid_d = 1'b0;
            state_d         = ST_PARITY;
          end else begin
            rtr_data_d = rd_data;
            rd_ptr_d   = rd_ptr_q + LEN_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          rtr_data_d = 8'h00;
          pkt_sent_d = 1'b1;
          gap_cnt_d  = '0;
          state_d    = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      hdr_q           <= '0;
      parity_q        <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      gap_cnt_q       <= '0;
      rtr_data_q      <= '0;
      rtr_pkt_valid_q <= 1'b0;
      pkt_sent_q      <= 1'b0;
      req_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      hdr_q           <= hdr_d;
      parity_q        <= parity_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      gap_cnt_q       <= gap_cnt_d;
      rtr_data_q      <= rtr_data_d;
      rtr_pkt_valid_q <= rtr_pkt_valid_d;
      pkt_sent_q      <= pkt_sent_d;
      req_err_q       <= req_err_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign pl_ready      = (state_q == ST_FILL);
  assign rtr_data      = rtr_data_q;
  assign rtr_pkt_valid = rtr_pkt_valid_q;
  assign pkt_sent      = pkt_sent_q;
  assign req_err       = req_err_q;

endmodule

// File: doc/router_pkt_framer.md
Name: router_pkt_framer

Overview:
- Upstream source for the 1x3 router. Accepts a packet request (dest addr, payload length) plus a payload byte stream.
- Store-and-forward: buffers the whole payload, then drives the router's byte input as header, payload, even-XOR parity.
- Honours the router's busy stall on every byte, then inserts an inter-packet gap.

Parameters:
- MAX_LEN, 63, max payload bytes; also the buffer depth. Must fit the 6-bit length field.
- GAP_CYCLES, 2, idle cycles (rtr_pkt_valid=0) after parity before the next request is accepted.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  packet request present.
- req_addr  in  2  destination port 0..2; 3 is illegal.
- req_len  in  6  payload length 1..63; 0 is illegal.
- req_ready  out  1  high in IDLE only; request accepted on an edge with req_valid&req_ready.
- pl_valid  in  1  payload byte present.
- pl_data  in  8  payload byte.
- pl_ready  out  1  high in FILL only.
- busy  in  1  router busy; no router-side byte advances on an edge where busy=1.
- rtr_data  out  8  byte to router data_in.
- rtr_pkt_valid  out  1  to router pkt_valid; high for header and payload, low for parity.
- pkt_sent  out  1  one-cycle pulse when parity is consumed.
- req_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (async, immediate): state=IDLE, rtr_data=0, rtr_pkt_valid=0, pkt_sent=0, req_err=0, counters and parity=0. req_ready=1 once reset is released. Reset mid-packet drops rtr_pkt_valid in the same instant; buffer contents become don't-care.
- States: IDLE, FILL, HEADER, PAYLOAD, PARITY, GAP.
- IDLE, request accepted:
  - req_len==0 or req_addr==3: pulse req_err next cycle, stay IDLE.
  - Otherwise latch hdr={req_len,req_addr}, parity=hdr, wr_ptr=0, go FILL.
- FILL: each edge with pl_valid writes buf[wr_ptr], parity^=pl_data, wr_ptr++. The edge writing byte len-1 goes to HEADER with rtr_data=hdr, rtr_pkt_valid=1 (registered). pl_valid gaps simply stall FILL.
- Router-side transfer = rising edge in HEADER/PAYLOAD/PARITY with busy=0.
  - HEADER transfer: rtr_data=buf[0], rd_ptr=1, go PAYLOAD.
  - PAYLOAD transfer: if rd_ptr==len, rtr_data=parity, rtr_pkt_valid=0, go PARITY; else rtr_data=buf[rd_ptr], rd_ptr++.
  - PARITY transfer: rtr_data=0, pkt_sent=1 for one cycle, gap_cnt=0, go GAP.
- While busy=1, rtr_data and rtr_pkt_valid hold exactly.
- GAP: counts GAP_CYCLES edges, then IDLE. GAP_CYCLES=0 means straight to IDLE.
- Latency: header appears 1 cycle after the last payload byte is written. Unstalled packet occupies len+2 router cycles.
- Widths: pointers 6 bits. parity is an 8-bit XOR over header and all payload bytes. No wrap: a packet never exceeds MAX_LEN.
- req_valid is ignored outside IDLE. pl_valid is ignored outside FILL.

Optional Feature:
- Macro: ROUTER_FRAMER_PARITY_CORRUPT_EN.
- Defined: adds input corrupt_parity (1 bit), sampled at request accept. If set, the transmitted parity byte is XORed with 8'h01, to exercise the router error path.
- Undefined: port absent; parity always correct.

Decomposition:
- Shared package router_pkg:
  - state enum.
  - ADDR_W=2, LEN_W=6, ADDR_ILLEGAL=2'b11.
  - function make_header(len,addr).
  - Reused by router-side checkers.
- Sub-module router_pkt_buf: MAX_LEN x 8 storage with synchronous write port and combinational read port (wr_en, wr_addr, wr_data, rd_addr, rd_data).

Test Plan:
- addr=0, len=14, busy=0: rtr_data sequence 0x38, 14 payload bytes, parity. rtr_pkt_valid high 15 cycles then low 1. pkt_sent 1 pulse. req_ready returns after 2 gap cycles.
- addr=1, len=1, payload 0xAA: bytes 0x05, 0xAA, 0xAF.
- busy held 3 cycles while the header is on rtr_data: header stable 4 cycles, then payload proceeds unchanged. Repeat with busy on payload byte 5 and on parity.
- len=0 and separately addr=3: req_err pulses once, rtr_pkt_valid never rises, next legal request accepted normally.
- len=63 addr=2, pl_valid toggling 50%: all 63 bytes in order, parity correct.
- reset asserted mid-PAYLOAD (byte 6): rtr_pkt_valid=0 immediately. After release, req_ready=1 and a fresh len=12 packet is correct.
- With ROUTER_FRAMER_PARITY_CORRUPT_EN and corrupt_parity=1 on len=1 addr=1 0xAA: parity byte 0xAE.
